// File: rtl/vga_pkg.sv
// Shared encodings for the VGA test-pattern generator: pattern modes, box
// direction states and the colour-bar table.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_BOX     = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

    // {R,G,B} on/off masks; index 0 is the leftmost bar (white) .. 7 (black)
    localparam logic [7:0][2:0] BAR_MASK = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: one INC/DEC direction FSM per axis, stepped once
// per enabled frame and clamped at the screen edges.
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int BOX_SIZE = 32,
    parameter int BOX_STEP = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_en,
    output logic [COORD_W-1:0] bx,
    output logic [COORD_W-1:0] by
);

    localparam logic [COORD_W:0] X_MAX = (COORD_W+1)'(H_ACTIVE - BOX_SIZE);
    localparam logic [COORD_W:0] Y_MAX = (COORD_W+1)'(V_ACTIVE - BOX_SIZE);
    localparam logic [COORD_W:0] STEP  = (COORD_W+1)'(BOX_STEP);

    dir_e               dx, dy, dx_n, dy_n;
    logic [COORD_W-1:0] bx_n, by_n;
    logic [COORD_W:0]   nx, ny;

    // Returns {next_dir, next_pos}; one extra bit of headroom so the sums never wrap
    function automatic logic [COORD_W:0] axis_next(input logic [COORD_W-1:0] pos,
                                                    input dir_e dir,
                                                    input logic [COORD_W:0] lim);
        logic [COORD_W:0] wide;
        wide = {1'b0, pos};
        if (dir == DIR_INC) begin
            if (wide + STEP >= lim) return {DIR_DEC, lim[COORD_W-1:0]};
            wide = wide + STEP;
            return {DIR_INC, wide[COORD_W-1:0]};
        end
        if (wide <= STEP) return {DIR_INC, {COORD_W{1'b0}}};
        wide = wide - STEP;
        return {DIR_DEC, wide[COORD_W-1:0]};
    endfunction

    always_comb begin
        bx_n = bx;
        by_n = by;
        dx_n = dx;
        dy_n = dy;
        nx   = axis_next(bx, dx, X_MAX);
        ny   = axis_next(by, dy, Y_MAX);
        if (step_en) begin
            bx_n = nx[COORD_W-1:0];
            by_n = ny[COORD_W-1:0];
            dx_n = dir_e'(nx[COORD_W]);
            dy_n = dir_e'(ny[COORD_W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bx <= '0;
            by <= '0;
            dx <= DIR_INC;
            dy <= DIR_INC;
        end else begin
            bx <= bx_n;
            by <= by_n;
            dx <= dx_n;
            dy <= dy_n;
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: per-frame mode/colour latch, four-pattern
// colour mux and a one-cycle registered RGB output.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int COLOR_W  = 4,
    parameter int COORD_W  = 10,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int CHK_LOG2 = 5,
    parameter int BOX_SIZE = 32,
    parameter int BOX_STEP = 4,
    parameter int FCNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COORD_W-1:0]   x,
    input  logic [COORD_W-1:0]   y,
    input  logic                 display,
    input  logic                 frame_tick,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic [COLOR_W-1:0]   vgaRed,
    output logic [COLOR_W-1:0]   vgaGreen,
    output logic [COLOR_W-1:0]   vgaBlue,
    output logic                 display_q,
    output logic [FCNT_W-1:0]    frame_cnt
);

    localparam int               BAR_W = H_ACTIVE / 8;
    localparam logic [COORD_W:0] BOX_W = (COORD_W+1)'(BOX_SIZE);

    mode_e                mode_q;
    logic [3*COLOR_W-1:0] solid_q, rgb_d, rgb_q;
    logic [2:0]           bar, mask;
    logic [COORD_W-1:0]   bx, by;
    logic                 in_box, box_step;

    // Mode is latched at the tick edge, so the tick-cycle check sees the old mode
    assign box_step = frame_tick && (mode_q == MODE_BOX);

    vga_box_mover #(
        .COORD_W (COORD_W),
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE),
        .BOX_SIZE(BOX_SIZE),
        .BOX_STEP(BOX_STEP)
    ) u_box (
        .clk    (clk),
        .rst    (rst),
        .step_en(box_step),
        .bx     (bx),
        .by     (by)
    );

    always_comb begin
        bar = '0;
        for (int k = 1; k < 8; k++)
            if ({1'b0, x} >= (COORD_W+1)'(k * BAR_W)) bar = 3'(k);

        in_box = ({1'b0, x} >= {1'b0, bx}) && ({1'b0, x} < {1'b0, bx} + BOX_W) &&
                 ({1'b0, y} >= {1'b0, by}) && ({1'b0, y} < {1'b0, by} + BOX_W);

        case (mode_q)
            MODE_BARS:    mask = BAR_MASK[bar];
            MODE_CHECKER: mask = {3{x[CHK_LOG2] ^ y[CHK_LOG2]}};
            MODE_BOX:     mask = in_box ? 3'b111 : 3'b001;
            default:      mask = 3'b000;
        endcase

        rgb_d = {{COLOR_W{mask[2]}}, {COLOR_W{mask[1]}}, {COLOR_W{mask[0]}}};
        if (mode_q == MODE_SOLID) rgb_d = solid_q;
        if (!display)             rgb_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q     <= '0;
            display_q <= 1'b0;
            frame_cnt <= '0;
            mode_q    <= MODE_SOLID;
            solid_q   <= '0;
        end else begin
            rgb_q     <= rgb_d;
            display_q <= display;
            if (frame_tick) begin
                mode_q    <= mode_e'(mode);
                solid_q   <= solid_rgb;
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end
    end

    assign vgaRed   = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign vgaGreen = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign vgaBlue  = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: reference model of the visible pattern and box
// motion, a vector table, corner-case sequences and randomized traffic.
module tb_vga_pattern_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  x = '0, y = '0;
    logic        display = 1'b0, frame_tick = 1'b0;
    logic [1:0]  mode = '0;
    logic [11:0] solid_rgb = '0;
    logic [3:0]  vgaRed, vgaGreen, vgaBlue;
    logic        display_q;
    logic [7:0]  frame_cnt;

    int vectors = 0, miscompares = 0;

    // Reference state: box as signed position/velocity, frame count modulo 256
    int          m_mode, m_fcnt, m_bx, m_by, m_dx, m_dy;
    logic [11:0] m_solid;
    logic [11:0] last_rgb;
    logic [11:0] bar_col [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    typedef struct {
        int          px;
        int          py;
        bit          disp;
        bit          tick;
        int          md;
        logic [11:0] exp;
    } vec_t;
    vec_t tbl[$];

    vga_pattern_gen dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .display   (display),
        .frame_tick(frame_tick),
        .mode      (mode),
        .solid_rgb (solid_rgb),
        .vgaRed    (vgaRed),
        .vgaGreen  (vgaGreen),
        .vgaBlue   (vgaBlue),
        .display_q (display_q),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_solid = '0; m_fcnt = 0;
        m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
    endtask

    function automatic logic [11:0] ref_pix(input int px, input int py, input bit disp);
        int bar;
        if (!disp) return 12'h000;
        case (m_mode)
            0: return m_solid;
            1: begin
                bar = px / 80;
                if (bar > 7) bar = 7;
                return bar_col[bar];
            end
            2: return (((px / 32) + (py / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
            default: return (px >= m_bx && px < m_bx + 32 && py >= m_by && py < m_by + 32)
                            ? 12'hFFF : 12'h00F;
        endcase
    endfunction

    task automatic move(inout int p, inout int d, input int lim);
        int n;
        n = p + d * 4;
        if (n >= lim) begin n = lim; d = -1; end
        else if (n <= 0) begin n = 0; d = 1; end
        p = n;
    endtask

    // One clock: apply inputs, compare against the model after the edge
    task automatic drive(input int px, input int py, input bit disp, input bit tick,
                         input int md, input logic [11:0] sol);
        logic [11:0] e;
        x = px[9:0]; y = py[9:0]; display = disp; frame_tick = tick;
        mode = md[1:0]; solid_rgb = sol;
        e = ref_pix(px, py, disp);
        @(posedge clk);
        #1;
        if (tick) begin
            if (m_mode == 3) begin
                move(m_bx, m_dx, 608);
                move(m_by, m_dy, 448);
            end
            m_mode = md; m_solid = sol; m_fcnt = (m_fcnt + 1) % 256;
        end
        last_rgb = {vgaRed, vgaGreen, vgaBlue};
        check("model", {11'b0, frame_cnt, display_q, last_rgb},
              {11'b0, m_fcnt[7:0], disp, e});
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rgb", {vgaRed, vgaGreen, vgaBlue}, 12'h000);
        check("reset_dq_fcnt", {display_q, frame_cnt}, 9'h000);
        rst = 1'b0;

        // Solid colour, then blanking
        drive(0, 0, 0, 1, 0, 12'hF00);
        drive(100, 5, 1, 0, 0, 12'h000);
        check("solid_red", last_rgb, 12'hF00);
        drive(100, 5, 0, 0, 0, 12'h000);
        check("blank", last_rgb, 12'h000);
        drive(100, 5, 1, 0, 0, 12'h000);

        // Asynchronous reset mid-line: outputs clear without a clock edge
        rst = 1'b1; display = 1'b1; x = 10'd200;
        #1;
        check("async_rst_rgb", {vgaRed, vgaGreen, vgaBlue}, 12'h000);
        check("async_rst_dq_fcnt", {display_q, frame_cnt}, 9'h000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drive(100, 5, 1, 0, 0, 12'hABC);
        check("post_rst_black", {display_q, last_rgb}, {1'b1, 12'h000});

        // Table: colour bars then checkerboard
        tbl.push_back('{0,   0,  0, 1, 1, 12'h000});
        tbl.push_back('{0,   0,  1, 0, 1, 12'hFFF});
        tbl.push_back('{79,  0,  1, 0, 1, 12'hFFF});
        tbl.push_back('{80,  0,  1, 0, 1, 12'hFF0});
        tbl.push_back('{160, 9,  1, 0, 1, 12'h0FF});
        tbl.push_back('{240, 9,  1, 0, 1, 12'h0F0});
        tbl.push_back('{320, 9,  1, 0, 1, 12'hF0F});
        tbl.push_back('{400, 9,  1, 0, 1, 12'hF00});
        tbl.push_back('{559, 9,  1, 0, 1, 12'h00F});
        tbl.push_back('{560, 9,  1, 0, 1, 12'h000});
        tbl.push_back('{639, 9,  1, 0, 1, 12'h000});
        tbl.push_back('{0,   0,  0, 1, 2, 12'h000});
        tbl.push_back('{0,   0,  1, 0, 2, 12'h000});
        tbl.push_back('{32,  0,  1, 0, 2, 12'hFFF});
        tbl.push_back('{32,  32, 1, 0, 2, 12'h000});
        tbl.push_back('{0,   32, 1, 0, 2, 12'hFFF});
        tbl.push_back('{31,  31, 1, 0, 2, 12'h000});
        foreach (tbl[i]) begin
            drive(tbl[i].px, tbl[i].py, tbl[i].disp, tbl[i].tick, tbl[i].md, 12'h000);
            check("table", last_rgb, tbl[i].exp);
        end
        for (int px = 0; px < 640; px++) drive(px, 3, 1, 0, 2, 12'h000);

        // Bouncing box: first tick only latches mode 3
        drive(0, 0, 0, 1, 3, 12'h000);
        for (int k = 1; k <= 160; k++) begin
            drive(0, 0, 0, 1, 3, 12'h000);
            drive(m_bx, m_by, 1, 0, 3, 12'h000);
            drive(m_bx + 31, m_by + 31, 1, 0, 3, 12'h000);
            drive(m_bx + 32, m_by, 1, 0, 3, 12'h000);
            if (k == 152) begin
                drive(608, 288, 1, 0, 3, 12'h000); check("box_right_edge", last_rgb, 12'hFFF);
                drive(607, 288, 1, 0, 3, 12'h000); check("box_left_of_edge", last_rgb, 12'h00F);
            end
            if (k == 153) begin
                drive(604, 284, 1, 0, 3, 12'h000); check("box_back_in", last_rgb, 12'hFFF);
                drive(603, 284, 1, 0, 3, 12'h000); check("box_left_out", last_rgb, 12'h00F);
                drive(635, 284, 1, 0, 3, 12'h000); check("box_last_col", last_rgb, 12'hFFF);
                drive(636, 284, 1, 0, 3, 12'h000); check("box_past_col", last_rgb, 12'h00F);
            end
        end

        // Mode switch on the tick cycle, then frame-counter wrap
        pulse_reset();
        drive(0, 0, 0, 1, 0, 12'h5A3);
        drive(0, 0, 1, 1, 1, 12'h5A3);
        check("switch_old_mode", last_rgb, 12'h5A3);
        drive(0, 0, 1, 0, 1, 12'h000);
        check("switch_new_mode", last_rgb, 12'hFFF);
        for (int i = 0; i < 253; i++) drive(0, 0, 0, 1, 1, 12'h000);
        check("fcnt_255", {24'b0, frame_cnt}, 32'd255);
        drive(0, 0, 0, 1, 1, 12'h000);
        check("fcnt_wrap", {24'b0, frame_cnt}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(639), $urandom_range(479), $urandom_range(3) != 0,
                  $urandom_range(15) == 0, $urandom_range(3), 12'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
